apb_req_arbiter: RTL and testbench

//  Shares the single APB requester port between NUM_REQ on-chip clients and sequences the APB protocol.
//  - Arbitration is round-robin.
//  - Drives PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB/PPROT into the apb_if bridge-side signals.
//  - Returns PRDATA/PSLVERR to the winning client.
//  - Sits between client logic and apb_if.

---
 rtl/apb_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/apb_req_arbiter.sv | 174 +++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared types and constants for the APB requester arbiter.
//   ADDR_WIDTH / DATA_WIDTH / STRB_WIDTH  default APB bus widths
//   PPROT_DEFAULT                         protection attributes driven on every access
//   apb_state_e                           APB phase state encoding
//   apb_cmd_t                             registered command of the granted client
package apb_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [2:0] PPROT_DEFAULT = 3'b000;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] strb;
  } apb_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick among N requesters.
//   req      in   N        pending requests
//   ptr      in   IDX_W    highest-priority index for this pick
//   en       in   1        allow a grant this cycle
//   gnt      out  N        one-hot grant (all zero when en=0 or no request)
//   gnt_idx  out  IDX_W    binary index of the granted requester
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Walk from ptr upward with wrap; the first pending request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = IDX_W'((int'(ptr) + i) % N);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: shares one APB requester port between NUM_REQ clients
// (round-robin) and sequences SETUP/ACCESS phases.
//   pclk, presetn                   clock, async active-low reset
//   req_valid/req_ready             per-client handshake (ready one-hot, IDLE only)
//   req_write/addr/wdata/strb       per-client command, packed client-major
//   rsp_valid                       one-cycle completion pulse to the owner
//   rsp_rdata, rsp_slverr           shared completion data/status
//   psel..pprot                     APB requester outputs
//   pready, pslverr, prdata         APB completer response
// Optional build macro APB_TIMEOUT_EN: abandons an ACCESS phase after
// TIMEOUT_CYCLES wait states and reports it as a slave error.
//
// state      | meaning
// APB_IDLE   | arbitrate; grant registers the winner's command
// APB_SETUP  | psel=1, penable=0 for one cycle
// APB_ACCESS | psel=1, penable=1 until pready (or timeout)
module apb_req_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = apb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH     = apb_pkg::DATA_WIDTH,
  parameter int STRB_WIDTH     = apb_pkg::STRB_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                           pclk,
  input  logic                           presetn,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_REQ*STRB_WIDTH-1:0]  req_strb,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_slverr,
  output logic                           psel,
  output logic                           penable,
  output logic                           pwrite,
  output logic [ADDR_WIDTH-1:0]          paddr,
  output logic [DATA_WIDTH-1:0]          pwdata,
  output logic [STRB_WIDTH-1:0]          pstrb,
  output logic [2:0]                     pprot,
  input  logic                           pready,
  input  logic                           pslverr,
  input  logic [DATA_WIDTH-1:0]          prdata
);

  localparam int IDX_W = $clog2(NUM_REQ);

  apb_state_e state_q, state_d;
  apb_cmd_t   cmd_q;

  logic [IDX_W-1:0]      owner_q;
  logic [IDX_W-1:0]      rr_ptr_q;
  logic [NUM_REQ-1:0]    gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  arb_en;
  logic                  access_done;
  logic                  access_tmo;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_WIDTH-1:0] sel_strb;

  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_slverr_q;

  // presetn in the enable keeps req_ready low while reset is held.
  assign arb_en = (state_q == APB_IDLE) && presetn;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign sel_addr  = req_addr [int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_strb  = req_strb [int'(gnt_idx)*STRB_WIDTH +: STRB_WIDTH];

  assign access_done = (state_q == APB_ACCESS) && pready;

`ifdef APB_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tmo_cnt_q <= '0;
    end else if (state_q == APB_SETUP) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == APB_ACCESS) && !pready) begin
      tmo_cnt_q <= tmo_cnt_q + 8'd1;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th ACCESS cycle that still sees no pready.
  assign access_tmo = (state_q == APB_ACCESS) && !pready &&
                      (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
  assign access_tmo     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      APB_IDLE:   if (|gnt) state_d = APB_SETUP;
      APB_SETUP:  state_d = APB_ACCESS;
      APB_ACCESS: if (access_done || access_tmo) state_d = APB_IDLE;
      default:    state_d = APB_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= APB_IDLE;
      cmd_q    <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (|gnt) begin
        cmd_q.write <= req_write[gnt_idx];
        cmd_q.addr  <= sel_addr;
        cmd_q.wdata <= sel_wdata;
        cmd_q.strb  <= req_write[gnt_idx] ? sel_strb : '0;
        owner_q     <= gnt_idx;
        rr_ptr_q    <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  // Completion is reported the cycle after the ACCESS phase ends.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      if (access_done) begin
        rsp_valid_q  <= NUM_REQ'(1) << owner_q;
        rsp_rdata_q  <= cmd_q.write ? '0 : prdata;
        rsp_slverr_q <= pslverr;
      end else if (access_tmo) begin
        rsp_valid_q  <= NUM_REQ'(1) << owner_q;
        rsp_rdata_q  <= '0;
        rsp_slverr_q <= 1'b1;
      end
    end
  end

  assign req_ready  = gnt;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_slverr = rsp_slverr_q;

  assign psel    = (state_q == APB_SETUP) || (state_q == APB_ACCESS);
  assign penable = (state_q == APB_ACCESS);
  assign pwrite  = cmd_q.write;
  assign paddr   = cmd_q.addr;
  assign pwdata  = cmd_q.wdata;
  assign pstrb   = cmd_q.strb;
  assign pprot   = PPROT_DEFAULT;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed stimulus with a grant/response scoreboard for
// apb_req_arbiter driving a small byte-strobed memory completer.
module tb_apb_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic            pclk = 1'b0;
  logic            presetn;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_strb;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_slverr;
  logic            psel, penable, pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [SW-1:0]   pstrb;
  logic [2:0]      pprot;
  logic            pready, pslverr;
  logic [DW-1:0]   prdata;

  always #5 pclk = ~pclk;

  apb_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  // Completer: ws wait states, err_mode 1 = pslverr with pready,
  // err_mode 2 = pslverr only during wait states.
  logic [DW-1:0] mem [0:63];
  int ws       = 0;
  int err_mode = 0;
  int acc_cnt  = 0;

  assign pready  = psel && penable && (acc_cnt == ws);
  assign pslverr = (err_mode == 1) ? pready :
                   (err_mode == 2) ? (psel && penable && !pready) : 1'b0;
  assign prdata  = mem[paddr[7:2]];

  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (psel && penable && pready && pwrite)
      for (int b = 0; b < SW; b++)
        if (pstrb[b]) mem[paddr[7:2]][8*b +: 8] <= pwdata[8*b +: 8];
  end

  typedef struct packed {
    logic [1:0]    c;
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  rsp_t rsp_q[$];
  int   gnt_q[$];
  rsp_t mon_e;
  int   mon_g;
  int   compared   = 0;
  int   mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_rsp(input int c, input logic [DW-1:0] rdata, input logic err);
    rsp_t e;
    e.c     = 2'(c);
    e.rdata = rdata;
    e.err   = err;
    rsp_q.push_back(e);
  endtask

  // Monitor: every grant and every completion pops its expectation.
  always @(negedge pclk) begin
    if (|req_ready) begin
      if (gnt_q.size() == 0) check("gnt_unexpected", 64'(req_ready), 64'd0);
      else begin
        mon_g = gnt_q.pop_front();
        check("gnt_order", 64'(req_ready), 64'd1 << mon_g);
      end
    end
    if (|rsp_valid) begin
      if (rsp_q.size() == 0) check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      else begin
        mon_e = rsp_q.pop_front();
        check("rsp_owner", 64'(rsp_valid), 64'd1 << mon_e.c);
        check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
        check("rsp_slverr", 64'(rsp_slverr), 64'(mon_e.err));
      end
    end
  end

  task automatic xfer(input int c, input logic w, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                      input logic [DW-1:0] exp_rdata, input logic exp_err,
                      input int exp_acc);
    int n;
    int acc;
    bit seen;
    bit stable;
    gnt_q.push_back(c);
    push_rsp(c, exp_rdata, exp_err);
    @(posedge pclk); #1;
    req_valid[c]           = 1'b1;
    req_write[c]           = w;
    req_addr[c*AW +: AW]   = addr;
    req_wdata[c*DW +: DW]  = wdata;
    req_strb[c*SW +: SW]   = strb;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 100) begin
      @(negedge pclk);
      seen = req_ready[c];
      n++;
    end
    check("ready_seen", 64'(seen), 64'd1);
    @(posedge pclk); #1;
    req_valid[c] = 1'b0;
    if (!seen) return;
    @(negedge pclk);
    check("setup_phase", 64'({psel, penable}), 64'b10);
    check("setup_paddr", 64'(paddr), 64'(addr));
    check("setup_pwrite", 64'(pwrite), 64'(w));
    check("setup_pstrb", 64'(pstrb), w ? 64'(strb) : 64'd0);
    if (w) check("setup_pwdata", 64'(pwdata), 64'(wdata));
    acc    = 0;
    stable = 1'b1;
    @(negedge pclk);
    while (psel && penable && acc < 200) begin
      acc++;
      if (paddr !== addr || pwrite !== w || (w && pwdata !== wdata)) stable = 1'b0;
      @(negedge pclk);
    end
    check("access_cycles", 64'(acc), 64'(exp_acc));
    check("access_stable", 64'(stable), 64'd1);
  endtask

  // Clients in mask read 0x40 + 4*i concurrently until ngrant grants are seen.
  task automatic multi(input logic [N-1:0] mask, input int ngrant, input bit drop_on_grant);
    int n;
    int g;
    @(posedge pclk); #1;
    for (int i = 0; i < N; i++) begin
      req_write[i]          = 1'b0;
      req_addr[i*AW +: AW]  = 32'h40 + 32'(4*i);
      req_strb[i*SW +: SW]  = 4'hF;
    end
    req_valid = mask;
    for (int k = 0; k < ngrant; k++) begin
      n = 0;
      g = -1;
      while (g < 0 && n < 100) begin
        @(negedge pclk);
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        n++;
      end
      check("multi_grant_seen", 64'(g >= 0), 64'd1);
      @(posedge pclk); #1;
      if (drop_on_grant && g >= 0) req_valid[g] = 1'b0;
    end
    req_valid = '0;
    repeat (8) @(negedge pclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int k = 0; k < 64; k++) mem[k] <= 32'h1000_0000 + 32'(k);
    presetn   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;

    // Reset state
    repeat (3) @(negedge pclk);
    check("rst_psel_penable", 64'({psel, penable}), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    presetn = 1'b1;
    repeat (2) @(negedge pclk);
    check("post_rst_psel", 64'(psel), 64'd0);
    check("post_rst_ready", 64'(req_ready), 64'd0);

    // Zero-wait write then readback by client 1 (rr_ptr 0 -> 2 -> 2)
    xfer(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1);
    xfer(1, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 1);

    // Client 3 alone (ptr 2 -> 0), then all four: 0,1,2,3,0 (ptr -> 1)
    xfer(3, 1'b0, 32'h4C, 32'h0, 4'hF, 32'h1000_0013, 1'b0, 1);
    gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(2);
    gnt_q.push_back(3); gnt_q.push_back(0);
    push_rsp(0, 32'h1000_0010, 1'b0);
    push_rsp(1, 32'h1000_0011, 1'b0);
    push_rsp(2, 32'h1000_0012, 1'b0);
    push_rsp(3, 32'h1000_0013, 1'b0);
    push_rsp(0, 32'h1000_0010, 1'b0);
    multi(4'b1111, 5, 1'b0);

    // Client 2 (ptr 1 -> 3); clients 0 and 3 with ptr 3: 3 wins first
    xfer(2, 1'b0, 32'h48, 32'h0, 4'hF, 32'h1000_0012, 1'b0, 1);
    gnt_q.push_back(3); gnt_q.push_back(0);
    push_rsp(3, 32'h1000_0013, 1'b0);
    push_rsp(0, 32'h1000_0010, 1'b0);
    multi(4'b1001, 2, 1'b1);

    // Two wait states, partial-strobe write then readback
    ws = 2;
    xfer(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'h5, 32'h0, 1'b0, 3);
    xfer(2, 1'b0, 32'h20, 32'h0, 4'hF, 32'h10FE_000D, 1'b0, 3);

    // Slave error with pready, then pslverr only during wait states
    ws = 0; err_mode = 1;
    xfer(2, 1'b0, 32'h3C, 32'h0, 4'hF, 32'h1000_000F, 1'b1, 1);
    ws = 2; err_mode = 2;
    xfer(3, 1'b0, 32'h3C, 32'h0, 4'hF, 32'h1000_000F, 1'b0, 3);
    err_mode = 0;

`ifdef APB_TIMEOUT_EN
    ws = 1000;
    xfer(0, 1'b0, 32'h44, 32'h0, 4'hF, 32'h0, 1'b1, 16);
    ws = 0;
    xfer(1, 1'b0, 32'h44, 32'h0, 4'hF, 32'h1000_0011, 1'b0, 1);
`else
    ws = 20;
    xfer(0, 1'b0, 32'h44, 32'h0, 4'hF, 32'h1000_0011, 1'b0, 21);
`endif

    // Reset during ACCESS: psel drops at once, no completion follows
    ws = 5;
    gnt_q.push_back(0);
    @(posedge pclk); #1;
    req_write[0]        = 1'b0;
    req_addr[0 +: AW]   = 32'h44;
    req_valid[0]        = 1'b1;
    n = 0;
    while (!req_ready[0] && n < 100) begin @(negedge pclk); n++; end
    @(posedge pclk); #1;
    req_valid[0] = 1'b0;
    n = 0;
    while (!(psel && penable) && n < 20) begin @(negedge pclk); n++; end
    check("reached_access", 64'(penable), 64'd1);
    #1 presetn = 1'b0;
    #1;
    check("rst_mid_psel_penable", 64'({psel, penable}), 64'd0);
    check("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (3) @(negedge pclk);
    ws = 0;
    presetn = 1'b1;
    repeat (8) @(negedge pclk);

    // rr_ptr restarted at 0: clients 0 and 1 -> 0 first
    gnt_q.push_back(0); gnt_q.push_back(1);
    push_rsp(0, 32'h1000_0010, 1'b0);
    push_rsp(1, 32'h1000_0011, 1'b0);
    multi(4'b0011, 2, 1'b1);

    check("gnt_queue_drained", 64'(gnt_q.size()), 64'd0);
    check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
